uc_multiciclo: RTL

Multicycle control unit for the processor datapath. It replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and write-back. It adds a per-channel I/O confirm handshake, configurable memory latency and an optional I/O timeout. It drives the same control bus into the datapath, plus IR/PC write strobes and a state readout.

---
 rtl/uc_multiciclo_if.sv | 50 +++++
 rtl/uc_multiciclo.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_multiciclo_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// uc_multiciclo_if: control bus between the multicycle control unit and datapath.
// Rev 1.0
//------------------------------------------------------------------------------
interface uc_multiciclo_if #(
   parameter int INSTR_W = 32,
   parameter int IO_CH   = 2
);
   localparam int CH_W = (IO_CH > 1) ? $clog2(IO_CH) : 1;

   logic [INSTR_W-1:0] instrucao;
   logic [IO_CH-1:0]   sinal;
   logic               escreveIR;
   logic               escrevePC;
   logic [1:0]         opULA;
   logic [2:0]         desvio;
   logic               memReg;
   logic               escreveMem;
   logic               escreveReg;
   logic [1:0]         origULA;
   logic [1:0]         ext;
   logic               out;
   logic               in;
   logic               stop;
   logic               jal;
   logic               offset_register;
   logic               lpc;
   logic               spc;
   logic               nextProgram;
   logic               endProgram;
   logic [CH_W-1:0]    io_sel;
   logic               io_timeout;
   logic [2:0]         estado;

   modport master (
      input  instrucao, sinal,
      output escreveIR, escrevePC, opULA, desvio, memReg, escreveMem, escreveReg,
             origULA, ext, out, in, stop, jal, offset_register, lpc, spc,
             nextProgram, endProgram, io_sel, io_timeout, estado
   );

   modport slave (
      output instrucao, sinal,
      input  escreveIR, escrevePC, opULA, desvio, memReg, escreveMem, escreveReg,
             origULA, ext, out, in, stop, jal, offset_register, lpc, spc,
             nextProgram, endProgram, io_sel, io_timeout, estado
   );
endinterface
`default_nettype wire

// File: rtl/uc_multiciclo.sv
`default_nettype none
//------------------------------------------------------------------------------
// uc_multiciclo: Moore multicycle control unit (F/D/E/MEM/WB/IO_WAIT/HALT).
// Optional I/O wait timeout enabled by UC_IO_TIMEOUT_EN.  Rev 1.0
//------------------------------------------------------------------------------
module uc_multiciclo #(
   parameter int INSTR_W     = 32,
   parameter int IO_CH       = 2,
   parameter int MEM_LAT     = 1,
   parameter int TIMEOUT_CYC = 1024
) (
   input  wire logic       clock,
   input  wire logic       resetn,
   uc_multiciclo_if.master bus
);
   localparam int CH_W = (IO_CH > 1) ? $clog2(IO_CH) : 1;
   localparam int MC_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

   localparam logic [5:0] OP_R    = 6'h00, OP_ADDI = 6'h01, OP_SUBI = 6'h02,
                          OP_J    = 6'h03, OP_JR   = 6'h04, OP_BEQ  = 6'h05,
                          OP_BNE  = 6'h06, OP_BLT  = 6'h07, OP_BGT  = 6'h08,
                          OP_BLE  = 6'h09, OP_BGE  = 6'h0A, OP_LW   = 6'h0B,
                          OP_SW   = 6'h0C, OP_JAL  = 6'h0D, OP_OUT  = 6'h0E,
                          OP_IN   = 6'h0F, OP_HALT = 6'h11, OP_SPC  = 6'h21,
                          OP_LC   = 6'h2B, OP_SC   = 6'h2C, OP_LPC  = 6'h2F,
                          OP_NEXT = 6'h3F;

   typedef enum logic [2:0] {
      S_INIT = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
      S_MEM  = 3'd4, S_WB    = 3'd5, S_IO_WAIT = 3'd6, S_HALT = 3'd7
   } state_t;

   typedef struct packed {
      logic       escreveIR;
      logic       escrevePC;
      logic [1:0] opULA;
      logic [2:0] desvio;
      logic       memReg;
      logic       escreveMem;
      logic       escreveReg;
      logic [1:0] origULA;
      logic [1:0] ext;
      logic       out;
      logic       in;
      logic       stop;
      logic       jal;
      logic       offset_register;
      logic       lpc;
      logic       spc;
      logic       nextProgram;
      logic       endProgram;
   } ctrl_t;

   state_t          state_q, state_d;
   logic [5:0]      op_q, op_d;
   logic [CH_W-1:0] ch_q, ch_d;
   logic [IO_CH-1:0] prev_q;
   logic [MC_W-1:0] mem_cnt_q, mem_cnt_d;
   ctrl_t           ctrl_q;
   logic [CH_W-1:0] io_sel_q;

   logic [5:0]      op_in;
   logic [CH_W-1:0] ch_in;
   logic            confirm;
   logic            is_load;

   assign op_in   = bus.instrucao[INSTR_W-1 -: 6];
   assign ch_in   = bus.instrucao[CH_W-1:0];
   assign confirm = bus.sinal[ch_q] & ~prev_q[ch_q];
   assign is_load = (op_q == OP_LW) || (op_q == OP_LC);

   // Outputs are registered from the next state, so they line up with state_q.
   function automatic ctrl_t decode(input state_t s, input logic [5:0] op, input logic mem_first);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.escreveIR = 1'b1;
            c.escrevePC = 1'b1;
         end
         S_EXEC: begin
            case (op)
               OP_R:    c.opULA = 2'b01;
               OP_ADDI: begin c.origULA = 2'b01; c.opULA = 2'b11; end
               OP_SUBI: begin c.origULA = 2'b01; c.opULA = 2'b10; end
               OP_J:    begin c.desvio = 3'b001; c.ext = 2'b01; end
               OP_JR:   begin c.desvio = 3'b011; c.ext = 2'b01; end
               OP_JAL:  begin c.desvio = 3'b001; c.ext = 2'b01; c.jal = 1'b1; end
               OP_BEQ:  begin c.origULA = 2'b10; c.desvio = 3'b010; c.opULA = 2'b10; end
               OP_BNE:  begin c.origULA = 2'b10; c.desvio = 3'b100; c.opULA = 2'b10; end
               OP_BLT:  begin c.origULA = 2'b10; c.desvio = 3'b101; c.opULA = 2'b11; end
               OP_BGT:  begin c.origULA = 2'b10; c.desvio = 3'b101; c.opULA = 2'b10; end
               OP_BLE:  begin c.origULA = 2'b10; c.desvio = 3'b110; c.opULA = 2'b11; end
               OP_BGE:  begin c.origULA = 2'b10; c.desvio = 3'b110; c.opULA = 2'b10; end
               OP_LW, OP_LC, OP_SW, OP_SC: begin
                  c.origULA         = 2'b01;
                  c.opULA           = 2'b11;
                  c.offset_register = (op == OP_LC) || (op == OP_SC);
               end
               OP_LPC:  c.lpc = 1'b1;
               OP_SPC:  c.spc = 1'b1;
               OP_NEXT: c.nextProgram = 1'b1;
               default: c = '0;
            endcase
         end
         S_MEM: begin
            if (op == OP_LW || op == OP_LC || op == OP_SW || op == OP_SC) begin
               c.origULA         = 2'b01;
               c.opULA           = 2'b11;
               c.offset_register = (op == OP_LC) || (op == OP_SC);
               c.memReg          = (op == OP_LW) || (op == OP_LC);
               c.escreveMem      = ((op == OP_SW) || (op == OP_SC)) && mem_first;
            end
         end
         S_WB: begin
            case (op)
               OP_R:    begin c.opULA = 2'b01; c.escreveReg = 1'b1; end
               OP_ADDI: begin c.origULA = 2'b01; c.opULA = 2'b11; c.escreveReg = 1'b1; end
               OP_SUBI: begin c.origULA = 2'b01; c.opULA = 2'b10; c.escreveReg = 1'b1; end
               OP_LW, OP_LC: begin
                  c.origULA         = 2'b01;
                  c.opULA           = 2'b11;
                  c.memReg          = 1'b1;
                  c.escreveReg      = 1'b1;
                  c.offset_register = (op == OP_LC);
               end
               OP_IN: begin
                  c.ext = 2'b10; c.opULA = 2'b11; c.origULA = 2'b01; c.escreveReg = 1'b1;
               end
               default: c = '0;
            endcase
         end
         S_IO_WAIT: begin
            if (op == OP_OUT) begin
               c.out  = 1'b1;
               c.stop = 1'b1;
            end else if (op == OP_IN) begin
               c.in    = 1'b1;
               c.stop  = 1'b1;
               c.opULA = 2'b10;
            end
         end
         S_HALT:  c.endProgram = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

`ifdef UC_IO_TIMEOUT_EN
   localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            timeout_d, timeout_q;
`endif

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      ch_d      = ch_q;
      mem_cnt_d = '0;
`ifdef UC_IO_TIMEOUT_EN
      to_cnt_d  = '0;
      timeout_d = 1'b0;
`endif
      case (state_q)
         S_INIT:  state_d = S_FETCH;
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            op_d = op_in;
            ch_d = ch_in;
            case (op_in)
               OP_OUT, OP_IN: state_d = (int'(ch_in) < IO_CH) ? S_IO_WAIT : S_EXEC;
               OP_HALT:       state_d = S_HALT;
               default:       state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (op_q)
               OP_R, OP_ADDI, OP_SUBI:    state_d = S_WB;
               OP_LW, OP_LC, OP_SW, OP_SC: state_d = S_MEM;
               default:                   state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (mem_cnt_q == MC_W'(MEM_LAT - 1)) begin
               state_d = is_load ? S_WB : S_FETCH;
            end else begin
               mem_cnt_d = mem_cnt_q + 1'b1;
            end
         end
         S_WB: state_d = S_FETCH;
         S_IO_WAIT: begin
            // A confirm on the expiry cycle takes priority over the timeout.
            if (confirm) begin
               state_d = (op_q == OP_IN) ? S_WB : S_FETCH;
            end
`ifdef UC_IO_TIMEOUT_EN
            else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
               state_d   = S_FETCH;
               timeout_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
`endif
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q   <= S_INIT;
         op_q      <= '0;
         ch_q      <= '0;
         prev_q    <= '0;
         mem_cnt_q <= '0;
         ctrl_q    <= '0;
         io_sel_q  <= '0;
`ifdef UC_IO_TIMEOUT_EN
         to_cnt_q  <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         ch_q      <= ch_d;
         prev_q    <= bus.sinal;
         mem_cnt_q <= mem_cnt_d;
         ctrl_q    <= decode(state_d, op_d, (mem_cnt_d == '0));
         io_sel_q  <= (state_d == S_IO_WAIT) ? ch_d : '0;
`ifdef UC_IO_TIMEOUT_EN
         to_cnt_q  <= to_cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

`ifdef UC_IO_TIMEOUT_EN
   assign bus.io_timeout = timeout_q;
`else
   assign bus.io_timeout = 1'b0;
`endif

   assign bus.escreveIR       = ctrl_q.escreveIR;
   assign bus.escrevePC       = ctrl_q.escrevePC;
   assign bus.opULA           = ctrl_q.opULA;
   assign bus.desvio          = ctrl_q.desvio;
   assign bus.memReg          = ctrl_q.memReg;
   assign bus.escreveMem      = ctrl_q.escreveMem;
   assign bus.escreveReg      = ctrl_q.escreveReg;
   assign bus.origULA         = ctrl_q.origULA;
   assign bus.ext             = ctrl_q.ext;
   assign bus.out             = ctrl_q.out;
   assign bus.in              = ctrl_q.in;
   assign bus.stop            = ctrl_q.stop;
   assign bus.jal             = ctrl_q.jal;
   assign bus.offset_register = ctrl_q.offset_register;
   assign bus.lpc             = ctrl_q.lpc;
   assign bus.spc             = ctrl_q.spc;
   assign bus.nextProgram     = ctrl_q.nextProgram;
   assign bus.endProgram      = ctrl_q.endProgram;
   assign bus.io_sel          = io_sel_q;
   assign bus.estado          = state_q;
endmodule
`default_nettype wire
